// File: rtl/arm_multicycle_control_unit.sv
// Multicycle ARM-subset control unit: Moore FSM sequencing fetch, decode, execute and writeback,
// with the condition flags register and predication.
module arm_multicycle_control_unit (
  input  logic        i_CLK,
  input  logic        i_RESET,
  input  logic [31:0] i_Instr,
  input  logic [3:0]  i_ALU_Flags,
  output logic        o_PC_Write,
  output logic        o_AddressSrc,
  output logic        o_MemWrite,
  output logic        o_InstructionWrite,
  output logic [1:0]  o_RegSrc,
  output logic        o_RegWrite,
  output logic [1:0]  o_ImmediateSrc,
  output logic        o_ALU_Src_A,
  output logic [1:0]  o_ALU_Src_B,
  output logic [1:0]  o_ALU_Control,
  output logic [1:0]  o_ResultSrc,
  output logic        o_Undef
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       address_src;
    logic       mem_write;
    logic       instr_write;
    logic [1:0] reg_src;
    logic       reg_write;
    logic [1:0] imm_src;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] alu_ctrl;
    logic [1:0] result_src;
    logic       undef;
  } ctrl_t;

  state_t     state_q;
  logic       cond_q;
  logic [3:0] flags_q;

  logic [1:0] op_s;
  logic [3:0] cmd_s;
  logic       imm_bit_s;
  logic       s_bit_s;
  logic       u_bit_s;
  logic       dp_valid_s;
  logic       mem_valid_s;
  logic       is_cmp_s;
  logic       is_logic_s;
  logic [1:0] dp_alu_s;
  logic       decode_undef_s;
  ctrl_t      ctrl_s;

  assign op_s      = i_Instr[27:26];
  assign imm_bit_s = i_Instr[25];
  assign cmd_s     = i_Instr[24:21];
  assign s_bit_s   = i_Instr[20];
  assign u_bit_s   = i_Instr[23];
  assign is_cmp_s   = (cmd_s == 4'b1010);
  assign is_logic_s = (cmd_s == 4'b0000) || (cmd_s == 4'b1100);
  // Only pre-indexed, no-writeback, word, register-base with immediate offset is supported.
  assign mem_valid_s = i_Instr[24] & ~i_Instr[21] & ~i_Instr[22] & ~imm_bit_s;

  // Standard ARM condition codes over {N,Z,C,V}; 1111 is treated as never.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      4'b0000: cond_check = z;
      4'b0001: cond_check = ~z;
      4'b0010: cond_check = c;
      4'b0011: cond_check = ~c;
      4'b0100: cond_check = n;
      4'b0101: cond_check = ~n;
      4'b0110: cond_check = v;
      4'b0111: cond_check = ~v;
      4'b1000: cond_check = c & ~z;
      4'b1001: cond_check = ~c | z;
      4'b1010: cond_check = (n == v);
      4'b1011: cond_check = (n != v);
      4'b1100: cond_check = ~z & (n == v);
      4'b1101: cond_check = z | (n != v);
      4'b1110: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

  // Data-processing command decode: ALU operation and legality.
  always_comb begin
    dp_alu_s   = 2'b00;
    dp_valid_s = 1'b1;
    case (cmd_s)
      4'b0100: dp_alu_s = 2'b00;
      4'b0010: dp_alu_s = 2'b01;
      4'b0000: dp_alu_s = 2'b10;
      4'b1100: dp_alu_s = 2'b11;
      4'b1010: begin
        dp_alu_s   = 2'b01;
        dp_valid_s = s_bit_s;
      end
      default: dp_valid_s = 1'b0;
    endcase
  end

  // Flags the instruction register contents as unsupported.
  always_comb begin
    case (op_s)
      2'b00:   decode_undef_s = ~dp_valid_s;
      2'b01:   decode_undef_s = ~mem_valid_s;
      2'b10:   decode_undef_s = 1'b0;
      default: decode_undef_s = 1'b1;
    endcase
  end

  // State sequencing, predicate capture and flags register.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q <= S_FETCH;
      cond_q  <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      case (state_q)
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          cond_q <= cond_check(i_Instr[31:28], flags_q);
          if (decode_undef_s) begin
            state_q <= S_FETCH;
          end else begin
            case (op_s)
              2'b00:   state_q <= imm_bit_s ? S_EXECI : S_EXECR;
              2'b01:   state_q <= S_MEMADR;
              default: state_q <= S_BRANCH;
            endcase
          end
        end
        S_EXECR, S_EXECI: begin
          state_q <= is_cmp_s ? S_FETCH : S_ALUWB;
          if (s_bit_s && cond_q) begin
            flags_q <= is_logic_s ? {i_ALU_Flags[3:2], flags_q[1:0]} : i_ALU_Flags;
          end else begin
            flags_q <= flags_q;
          end
        end
        S_MEMADR:  state_q <= i_Instr[20] ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD: state_q <= S_MEMWB;
        default:   state_q <= S_FETCH;
      endcase
    end
  end

  // Moore output decode. Decode-cycle outputs depend on the instruction just loaded into the
  // IR, so they cannot be precomputed a cycle early; reset forces everything low at once.
  always_comb begin
    ctrl_s = '0;
    if (i_RESET) begin
      ctrl_s = '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          ctrl_s.instr_write = 1'b1;
          ctrl_s.src_a       = 1'b1;
          ctrl_s.src_b       = 2'b10;
          ctrl_s.result_src  = 2'b10;
          ctrl_s.pc_write    = 1'b1;
        end
        S_DECODE: begin
          ctrl_s.src_a      = 1'b1;
          ctrl_s.src_b      = 2'b10;
          ctrl_s.result_src = 2'b10;
          ctrl_s.reg_src    = {op_s == 2'b01, op_s == 2'b10};
          ctrl_s.undef      = decode_undef_s;
        end
        S_EXECR: begin
          ctrl_s.alu_ctrl = dp_alu_s;
        end
        S_EXECI: begin
          ctrl_s.src_b    = 2'b01;
          ctrl_s.alu_ctrl = dp_alu_s;
        end
        S_ALUWB: begin
          ctrl_s.reg_write = cond_q;
        end
        S_MEMADR: begin
          ctrl_s.src_b    = 2'b01;
          ctrl_s.imm_src  = 2'b01;
          ctrl_s.alu_ctrl = u_bit_s ? 2'b00 : 2'b01;
        end
        S_MEMREAD: begin
          ctrl_s.address_src = 1'b1;
        end
        S_MEMWB: begin
          ctrl_s.result_src = 2'b01;
          ctrl_s.reg_write  = cond_q;
        end
        S_MEMWRITE: begin
          ctrl_s.address_src = 1'b1;
          ctrl_s.reg_src     = 2'b10;
          ctrl_s.mem_write   = cond_q;
        end
        S_BRANCH: begin
          ctrl_s.src_b      = 2'b01;
          ctrl_s.imm_src    = 2'b10;
          ctrl_s.result_src = 2'b10;
          ctrl_s.pc_write   = cond_q;
        end
        default: ctrl_s = '0;
      endcase
    end
  end

  assign o_PC_Write         = ctrl_s.pc_write;
  assign o_AddressSrc       = ctrl_s.address_src;
  assign o_MemWrite         = ctrl_s.mem_write;
  assign o_InstructionWrite = ctrl_s.instr_write;
  assign o_RegSrc           = ctrl_s.reg_src;
  assign o_RegWrite         = ctrl_s.reg_write;
  assign o_ImmediateSrc     = ctrl_s.imm_src;
  assign o_ALU_Src_A        = ctrl_s.src_a;
  assign o_ALU_Src_B        = ctrl_s.src_b;
  assign o_ALU_Control      = ctrl_s.alu_ctrl;
  assign o_ResultSrc        = ctrl_s.result_src;
  assign o_Undef            = ctrl_s.undef;

endmodule
